// File: rtl/bin2seg_bcd_if.sv
// Conversion request/result bundle between a value source and bin2seg_bcd.
// master drives the request side; slave (the formatter) drives status and digits.
interface bin2seg_bcd_if #(
    parameter int W = 27
);
    logic         start;
    logic         signed_mode;
    logic [W-1:0] bin;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [31:0]  x;

    modport master (
        output start, signed_mode, bin,
        input  busy, done, ovf, x
    );

    modport slave (
        input  start, signed_mode, bin,
        output busy, done, ovf, x
    );
endinterface

// File: rtl/bin2seg_bcd.sv
// Sequential binary-to-BCD formatter for the 8-digit scanner; x updates W+2 cycles after start.
// No backpressure: start is taken only in IDLE and is ignored (not queued) while busy.
module bin2seg_bcd #(
    parameter int W   = 27,
    parameter int LZB = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2seg_bcd_if.slave  io
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FORMAT} state_t;

    localparam logic [31:0] LIM_S = 32'd9_999_999;
    localparam logic [31:0] LIM_U = 32'd99_999_999;

    state_t       state;
    logic [W-1:0] bin_q;
    logic         sm_q;
    logic         neg;
    logic         ovf_pend;
    logic [W-1:0] shreg;
    logic [35:0]  bcd;
    logic [4:0]   cnt;

    logic [W:0]   mag;
    logic [35:0]  bcd_adj;
    logic [31:0]  fmt;
    int           msd;

    // One bit wider than the input so that negating -2^(W-1) stays exact.
    always_comb begin
        mag = {1'b0, bin_q};
        if (sm_q && bin_q[W-1])
            mag = -{1'b1, bin_q};
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 9; i++)
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // Digit 0 is always shown; the sign sits just left of the top shown digit.
    always_comb begin
        msd = 0;
        for (int i = 1; i < 8; i++)
            if (bcd[4*i +: 4] != 4'd0)
                msd = i;
        fmt = bcd[31:0];
        for (int i = 1; i < 8; i++) begin
            if (LZB != 0 && i > msd)
                fmt[4*i +: 4] = 4'hF;
            if (neg && ((LZB != 0 && i == msd + 1) || (LZB == 0 && i == 7)))
                fmt[4*i +: 4] = 4'hA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_q    <= '0;
            sm_q     <= 1'b0;
            neg      <= 1'b0;
            ovf_pend <= 1'b0;
            shreg    <= '0;
            bcd      <= '0;
            cnt      <= '0;
            io.busy  <= 1'b0;
            io.done  <= 1'b0;
            io.ovf   <= 1'b0;
            io.x     <= '1;
        end else begin
            io.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.start) begin
                        bin_q   <= io.bin;
                        sm_q    <= io.signed_mode;
                        io.busy <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    neg      <= sm_q & bin_q[W-1];
                    ovf_pend <= 32'(mag) > (sm_q ? LIM_S : LIM_U);
                    bcd      <= '0;
                    shreg    <= mag[W-1:0];
                    cnt      <= 5'(W - 1);
                    state    <= SHIFT;
                end
                SHIFT: begin
                    bcd   <= {bcd_adj[34:0], shreg[W-1]};
                    shreg <= {shreg[W-2:0], 1'b0};
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd0)
                        state <= FORMAT;
                end
                FORMAT: begin
                    io.x    <= ovf_pend ? 32'hAAAA_AAAA : fmt;
                    io.ovf  <= ovf_pend;
                    io.done <= 1'b1;
                    io.busy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2seg_bcd.sv
// Directed bench for bin2seg_bcd: two instances (blanking on/off) share stimulus,
// results are checked against an arithmetic decimal model through a scoreboard.
module tb_bin2seg_bcd;
    localparam int W = 27;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin2seg_bcd_if #(.W(W)) io1 ();
    bin2seg_bcd_if #(.W(W)) io0 ();

    assign io0.start       = io1.start;
    assign io0.signed_mode = io1.signed_mode;
    assign io0.bin         = io1.bin;

    bin2seg_bcd #(.W(W), .LZB(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(io1));
    bin2seg_bcd #(.W(W), .LZB(0)) dut0 (.clk(clk), .rst_n(rst_n), .io(io0));

    typedef struct {
        logic [26:0] b;
        logic        sm;
        logic [31:0] x1;
        logic [31:0] x0;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   nvec     = 0;
    int   nbad     = 0;
    int   done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decimal model by division, independent of the shift/add-3 structure.
    function automatic logic [32:0] model(input logic [26:0] b, input logic sm, input bit lzb);
        longint mag, lim, p;
        logic [31:0] r;
        bit neg;
        int nd;
        neg = sm && b[26];
        mag = neg ? -longint'($signed(b)) : longint'(b);
        lim = sm ? 64'sd9999999 : 64'sd99999999;
        if (mag > lim)
            return {1'b1, 32'hAAAA_AAAA};
        nd = 1;
        p  = 10;
        while (nd < 8 && mag >= p) begin
            nd++;
            p = p * 10;
        end
        r = '1;
        p = mag;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = (lzb && i >= nd) ? 4'hF : 4'(p % 10);
            p = p / 10;
        end
        if (neg)
            r[4*(lzb ? nd : 7) +: 4] = 4'hA;
        return {1'b0, r};
    endfunction

    task automatic push(input logic [26:0] b, input logic sm);
        exp_t e;
        logic [32:0] m1, m0;
        m1    = model(b, sm, 1'b1);
        m0    = model(b, sm, 1'b0);
        e.b   = b;
        e.sm  = sm;
        e.x1  = m1[31:0];
        e.x0  = m0[31:0];
        e.ovf = m1[32];
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (io1.done) begin
            done_cnt++;
            chk("sb_avail", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                me = sbq.pop_front();
                chk("x_lzb1", io1.x, me.x1);
                chk("x_lzb0", io0.x, me.x0);
                chk("ovf", 32'(io1.ovf), 32'(me.ovf));
                chk("done_lzb0", 32'(io0.done), 32'd1);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns cycles from E0 to done and busy-high count.
    task automatic run(input logic [26:0] b, input logic sm, output int lat, output int bc);
        io1.start       = 1'b1;
        io1.bin         = b;
        io1.signed_mode = sm;
        push(b, sm);
        @(negedge clk);
        io1.start       = 1'b0;
        io1.bin         = ~b;
        io1.signed_mode = ~sm;
        lat = 0;
        bc  = 0;
        while (!io1.done && lat < 200) begin
            if (io1.busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat, bc, base;
        io1.start       = 1'b0;
        io1.signed_mode = 1'b0;
        io1.bin         = '0;
        repeat (3) @(negedge clk);
        chk("rst_x", io1.x, 32'hFFFF_FFFF);
        chk("rst_busy", 32'(io1.busy), 32'd0);
        chk("rst_done", 32'(io1.done), 32'd0);
        chk("rst_ovf", 32'(io1.ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(27'd12345678, 1'b0, lat, bc);
        chk("t1_latency", 32'(lat), 32'd29);
        chk("t1_busy_cycles", 32'(bc), 32'd29);
        chk("t1_busy_low", 32'(io1.busy), 32'd0);

        run(27'd0, 1'b0, lat, bc);             chk("lat_zero_u", 32'(lat), 32'd29);
        run(27'd0, 1'b1, lat, bc);             chk("lat_zero_s", 32'(lat), 32'd29);
        run(27'h7FFFFD6, 1'b1, lat, bc);       chk("lat_m42", 32'(lat), 32'd29);
        run(27'(-9999999), 1'b1, lat, bc);     chk("lat_mmax", 32'(lat), 32'd29);
        run(27'd1234567, 1'b1, lat, bc);       chk("lat_spos", 32'(lat), 32'd29);
        run(27'd99999999, 1'b0, lat, bc);      chk("lat_umax", 32'(lat), 32'd29);
        run(27'd100000000, 1'b0, lat, bc);     chk("lat_ovf_u", 32'(lat), 32'd29);
        run(27'(-10000000), 1'b1, lat, bc);    chk("lat_ovf_s", 32'(lat), 32'd29);
        run(27'h4000000, 1'b1, lat, bc);       chk("lat_ovf_min", 32'(lat), 32'd29);
        run(27'd7, 1'b0, lat, bc);             chk("lat_seven", 32'(lat), 32'd29);

        repeat (5) @(negedge clk);
        chk("x_hold", io1.x, 32'hFFFF_FFF7);
        chk("ovf_hold", 32'(io1.ovf), 32'd0);

        // start held high: only IDLE-cycle samples are taken, one every W+3 cycles
        base = done_cnt;
        for (int k = 0; k < 90; k++) begin
            io1.start       = 1'b1;
            io1.signed_mode = 1'b0;
            io1.bin         = 27'(1000 * k + 7);
            if (k % 30 == 0)
                push(27'(1000 * k + 7), 1'b0);
            @(negedge clk);
        end
        io1.start = 1'b0;
        @(negedge clk);
        chk("t5_dones", 32'(done_cnt - base), 32'd3);
        chk("t5_idle", 32'(io1.busy), 32'd0);

        // asynchronous reset mid-conversion
        io1.start       = 1'b1;
        io1.bin         = 27'd555;
        io1.signed_mode = 1'b0;
        push(27'd555, 1'b0);
        @(negedge clk);
        io1.start = 1'b0;
        repeat (10) @(negedge clk);
        base  = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst_x", io1.x, 32'hFFFF_FFFF);
        chk("arst_busy", 32'(io1.busy), 32'd0);
        sbq.delete(sbq.size() - 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_done", 32'(done_cnt - base), 32'd0);

        run(27'd86420, 1'b0, lat, bc);
        chk("post_rst_latency", 32'(lat), 32'd29);
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
